// File: rtl/protected_operand_issuer.sv
// Initiator for the protected 3-op adder: encodes requests onto a parity/one-hot bus,
// samples the adder's two-rail error code, retries failed attempts and returns a response.
module protected_operand_issuer #(
  parameter int WIDTH     = 3,
  parameter int SETTLE    = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       inj_fault,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_err,
  output logic [1:0]       resp_retries,
  output logic [7:0]       err_cnt,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             par_o,
  output logic [2:0]       c_o,
  input  logic [WIDTH-1:0] x_i,
  input  logic             xc_i,
  input  logic [1:0]       xe_i
);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, GAP = 2'd2, RESP = 2'd3} state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [1:0]       retry_q, retry_d;
  logic [WIDTH-1:0] a_lat_q, a_lat_d, b_lat_q, b_lat_d;
  logic [1:0]       op_lat_q, op_lat_d;
  logic             req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_sum_q, resp_sum_d;
  logic             resp_cout_q, resp_cout_d, resp_err_q, resp_err_d;
  logic [1:0]       resp_retries_q, resp_retries_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0] a_o_q, a_o_d, b_o_q, b_o_d;
  logic             par_o_q, par_o_d;
  logic [2:0]       c_o_q, c_o_d;

  logic accept, sample, xe_ok, retry_left;

  assign accept     = req_valid && req_ready_q;
  assign sample     = (state_q == DRIVE) && (settle_q == SW'(SETTLE - 1));
  assign xe_ok      = (xe_i == 2'b10);
  assign retry_left = (retry_q < 2'(MAX_RETRY));

  // Returns {c, par}; fault injection corrupts parity and/or the one-hot control.
  function automatic logic [3:0] encode(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                        input logic [1:0] op, input logic [1:0] inj);
    logic [2:0] c;
    logic       par;
    c   = (op == 2'b00) ? 3'b001 : (op == 2'b01) ? 3'b010 : 3'b100;
    par = ~^{a, b};
    if (inj[1]) c = 3'b011;
    if (inj[0]) par = ~par;
    return {c, par};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      settle_q       <= '0;
      retry_q        <= '0;
      a_lat_q        <= '0;
      b_lat_q        <= '0;
      op_lat_q       <= '0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_sum_q     <= '0;
      resp_cout_q    <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_retries_q <= '0;
      err_cnt_q      <= '0;
      a_o_q          <= '0;
      b_o_q          <= '0;
      par_o_q        <= 1'b1;
      c_o_q          <= '0;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      retry_q        <= retry_d;
      a_lat_q        <= a_lat_d;
      b_lat_q        <= b_lat_d;
      op_lat_q       <= op_lat_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_sum_q     <= resp_sum_d;
      resp_cout_q    <= resp_cout_d;
      resp_err_q     <= resp_err_d;
      resp_retries_q <= resp_retries_d;
      err_cnt_q      <= err_cnt_d;
      a_o_q          <= a_o_d;
      b_o_q          <= b_o_d;
      par_o_q        <= par_o_d;
      c_o_q          <= c_o_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = (req_op == 2'b11) ? RESP : DRIVE;
      DRIVE: if (sample) state_d = (xe_ok || !retry_left) ? RESP : GAP;
      GAP:   state_d = DRIVE;
      RESP:  if (resp_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    settle_d       = settle_q;
    retry_d        = retry_q;
    a_lat_d        = a_lat_q;
    b_lat_d        = b_lat_q;
    op_lat_d       = op_lat_q;
    resp_sum_d     = resp_sum_q;
    resp_cout_d    = resp_cout_q;
    resp_err_d     = resp_err_q;
    resp_retries_d = resp_retries_q;
    err_cnt_d      = err_cnt_q;
    a_o_d          = '0;
    b_o_d          = '0;
    {c_o_d, par_o_d} = 4'b0001;
    req_ready_d    = (state_d == IDLE);
    resp_valid_d   = (state_d == RESP);

    if (state_q == IDLE && accept) begin
      a_lat_d  = req_a;
      b_lat_d  = req_b;
      op_lat_d = req_op;
      retry_d  = '0;
      settle_d = '0;
      if (req_op == 2'b11) begin
        resp_sum_d     = '0;
        resp_cout_d    = 1'b0;
        resp_err_d     = 1'b1;
        resp_retries_d = '0;
      end else begin
        a_o_d = req_a;
        b_o_d = req_b;
        {c_o_d, par_o_d} = encode(req_a, req_b, req_op, inj_fault);
      end
    end

    if (state_q == GAP) begin
      settle_d = '0;
      a_o_d    = a_lat_q;
      b_o_d    = b_lat_q;
      {c_o_d, par_o_d} = encode(a_lat_q, b_lat_q, op_lat_q, 2'b00);
    end

    if (state_q == DRIVE) begin
      if (!sample) begin
        settle_d = settle_q + SW'(1);
        a_o_d    = a_o_q;
        b_o_d    = b_o_q;
        c_o_d    = c_o_q;
        par_o_d  = par_o_q;
      end else begin
        resp_sum_d     = x_i;
        resp_cout_d    = xc_i;
        resp_err_d     = 1'b0;
        resp_retries_d = retry_q;
        if (!xe_ok) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          if (retry_left) retry_d = retry_q + 2'd1;
          else resp_err_d = 1'b1;
        end
      end
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_sum     = resp_sum_q;
  assign resp_cout    = resp_cout_q;
  assign resp_err     = resp_err_q;
  assign resp_retries = resp_retries_q;
  assign err_cnt      = err_cnt_q;
  assign a_o          = a_o_q;
  assign b_o          = b_o_q;
  assign par_o        = par_o_q;
  assign c_o          = c_o_q;
endmodule
